// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer: state encoding, the per-cycle
// stage-control bundle and the stall/freeze/advance priority rule.
package pipe_seq_ctrl_pkg;

   localparam int unsigned DefBootCycles = 2;
   localparam int unsigned DefMemTimeout = 16;
   localparam int unsigned DefStallCntW  = 16;

   // Sized for the largest legal BOOT_CYCLES (15) and MEM_TIMEOUT (255).
   localparam int unsigned BootCntW = 4;
   localparam int unsigned WaitCntW = 8;

   typedef enum logic [1:0] {
      StBoot    = 2'd0,
      StRun     = 2'd1,
      StMemWait = 2'd2,
      StHalt    = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic pc_le;
      logic npc_le;
      logic if_id_le;
      logic id_ex_le;
      logic ex_mem_le;
      logic mem_wb_le;
      logic flush_d;
      logic flush_e;
   } pipe_ctrl_t;

   // Memory wait freezes everything; a hazard holds the front end and bubbles ID/EX;
   // otherwise the pipe advances and the annul flush rides on the IF/ID load.
   function automatic pipe_ctrl_t pipe_ctrl(input logic busy, input logic stall,
                                            input logic annul);
      pipe_ctrl_t c;
      c = '0;
      if (!busy) begin
         if (stall) begin
            c.id_ex_le  = 1'b1;
            c.flush_e   = 1'b1;
            c.ex_mem_le = 1'b1;
            c.mem_wb_le = 1'b1;
         end else begin
            c.pc_le     = 1'b1;
            c.npc_le    = 1'b1;
            c.if_id_le  = 1'b1;
            c.id_ex_le  = 1'b1;
            c.ex_mem_le = 1'b1;
            c.mem_wb_le = 1'b1;
            c.flush_d   = annul;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: boot hold, hazard/memory-wait stage enables, annul flush,
// memory-timeout halt and a saturating front-end stall counter.
module pipe_seq_ctrl
   import pipe_seq_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = DefBootCycles,
   parameter int unsigned MEM_TIMEOUT = DefMemTimeout,
   parameter int unsigned STALL_CNT_W = DefStallCntW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hazard_stall,
   input  logic                   dmem_busy,
   input  logic                   annul_req,
   input  logic                   clr_stats,
   output logic                   PC_LE,
   output logic                   nPC_LE,
   output logic                   IF_ID_LE,
   output logic                   ID_EX_LE,
   output logic                   EX_MEM_LE,
   output logic                   MEM_WB_LE,
   output logic                   flush_D,
   output logic                   flush_E,
   output logic                   halted,
   output logic                   mem_timeout,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [BootCntW-1:0] BootLast   = BootCntW'(BOOT_CYCLES - 1);
   localparam logic [WaitCntW-1:0] TimeoutVal = WaitCntW'(MEM_TIMEOUT);

   seq_state_e             state_q, state_d;
   logic [BootCntW-1:0]    boot_cnt_q, boot_cnt_d;
   logic [WaitCntW-1:0]    wait_cnt_q, wait_cnt_d;
   logic                   mem_timeout_q, mem_timeout_d;
   pipe_ctrl_t             ctrl;
   logic                   stall_inc;

   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      ctrl          = '0;
      halted        = 1'b0;
      stall_inc     = 1'b0;

      unique case (state_q)
         StBoot: begin
            boot_cnt_d = boot_cnt_q + 1'b1;
            if (boot_cnt_q == BootLast) begin
               state_d = StRun;
            end
         end
         StRun: begin
            ctrl      = pipe_ctrl(dmem_busy, hazard_stall, annul_req);
            stall_inc = ~ctrl.pc_le;
            if (dmem_busy) begin
               state_d    = StMemWait;
               wait_cnt_d = WaitCntW'(1);
            end
         end
         StMemWait: begin
            ctrl      = pipe_ctrl(dmem_busy, hazard_stall, annul_req);
            stall_inc = ~ctrl.pc_le;
            if (dmem_busy) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_d == TimeoutVal) begin
                  state_d       = StHalt;
                  mem_timeout_d = 1'b1;
               end
            end else begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StBoot;
         boot_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .clr   (clr_stats),
      .count (stall_cycles)
   );

   assign PC_LE       = ctrl.pc_le;
   assign nPC_LE      = ctrl.npc_le;
   assign IF_ID_LE    = ctrl.if_id_le;
   assign ID_EX_LE    = ctrl.id_ex_le;
   assign EX_MEM_LE   = ctrl.ex_mem_le;
   assign MEM_WB_LE   = ctrl.mem_wb_le;
   assign flush_D     = ctrl.flush_d;
   assign flush_E     = ctrl.flush_e;
   assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed and randomized checks of pipe_seq_ctrl against a cycle-count based reference
// model (boot window, busy run length, saturating stall tally).
module tb_pipe_seq_ctrl;

   localparam int unsigned BOOT = 2;
   localparam int unsigned MT   = 8;
   localparam int unsigned SW   = 4;
   localparam int          SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          hazard_stall, dmem_busy, annul_req, clr_stats;
   logic          PC_LE, nPC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE;
   logic          flush_D, flush_E, halted, mem_timeout;
   logic [SW-1:0] stall_cycles;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int cyc;        // cycles since reset release, capped at BOOT
   bit halted_m;
   int busy_run;   // consecutive busy cycles while active
   int stall_m;

   pipe_seq_ctrl #(
      .BOOT_CYCLES (BOOT),
      .MEM_TIMEOUT (MT),
      .STALL_CNT_W (SW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hazard_stall (hazard_stall),
      .dmem_busy    (dmem_busy),
      .annul_req    (annul_req),
      .clr_stats    (clr_stats),
      .PC_LE        (PC_LE),
      .nPC_LE       (nPC_LE),
      .IF_ID_LE     (IF_ID_LE),
      .ID_EX_LE     (ID_EX_LE),
      .EX_MEM_LE    (EX_MEM_LE),
      .MEM_WB_LE    (MEM_WB_LE),
      .flush_D      (flush_D),
      .flush_E      (flush_E),
      .halted       (halted),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] dut_vec();
      return {PC_LE, nPC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE,
              flush_D, flush_E, halted, mem_timeout};
   endfunction

   // Order: PC nPC IF_ID ID_EX EX_MEM MEM_WB flush_D flush_E halted mem_timeout
   function automatic logic [9:0] model_vec(input logic busy, input logic haz,
                                            input logic annul);
      if (cyc < int'(BOOT)) return 10'b0;
      if (halted_m)         return 10'b00000000_11;
      if (busy)             return 10'b0;
      if (haz)              return 10'b000111_01_00;
      return {6'b111111, annul, 3'b000};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; checks this cycle, advances the model, ends at next falling edge.
   task automatic step(input logic busy, input logic haz, input logic annul, input logic clr);
      bit active;
      dmem_busy    = busy;
      hazard_stall = haz;
      annul_req    = annul;
      clr_stats    = clr;
      #1;
      chk("ctrl", {22'b0, dut_vec()}, {22'b0, model_vec(busy, haz, annul)});
      chk("stall_cycles", {28'b0, stall_cycles}, stall_m);
      active = (cyc >= int'(BOOT)) && !halted_m;
      if (clr) stall_m = 0;
      else if (active && (busy || haz) && stall_m < SMAX) stall_m++;
      if (active) begin
         if (busy) begin
            busy_run++;
            if (busy_run == int'(MT)) halted_m = 1'b1;
         end else begin
            busy_run = 0;
         end
      end
      if (cyc < int'(BOOT)) cyc++;
      @(negedge clk);
   endtask

   // Asynchronous reset with inputs left as they are; outputs must drop at once.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("reset_ctrl", {22'b0, dut_vec()}, 32'd0);
      chk("reset_stall", {28'b0, stall_cycles}, 32'd0);
      dmem_busy    = 1'b0;
      hazard_stall = 1'b0;
      annul_req    = 1'b0;
      clr_stats    = 1'b0;
      @(negedge clk);
      rst      = 1'b0;
      cyc      = 0;
      halted_m = 1'b0;
      busy_run = 0;
      stall_m  = 0;
   endtask

   initial begin
      int burst;
      rst          = 1'b1;
      dmem_busy    = 1'b0;
      hazard_stall = 1'b0;
      annul_req    = 1'b0;
      clr_stats    = 1'b0;
      @(negedge clk);
      do_reset();

      // Boot window then free run
      repeat (5) step(0, 0, 0, 0);
      // Three hazard cycles
      repeat (3) step(0, 1, 0, 0);
      chk("stall_after_hazard", {28'b0, stall_cycles}, 32'd3);
      // Annul held off by stall, then taken
      step(0, 1, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Memory wait with pending hazard, from a fresh reset
      do_reset();
      repeat (3) step(0, 0, 0, 0);
      repeat (4) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("stall_after_memwait", {28'b0, stall_cycles}, 32'd5);
      // Busy run of MT-1 must not halt
      repeat (MT - 1) step(1, 0, 0, 0);
      step(0, 0, 1, 0);

      // Saturation and clear-over-increment
      repeat (20) step(0, 1, 0, 0);
      chk("stall_saturated", {28'b0, stall_cycles}, SMAX);
      step(0, 1, 0, 1);
      step(0, 0, 0, 0);
      chk("stall_cleared", {28'b0, stall_cycles}, 32'd0);

      // Timeout: MT frozen cycles, then sticky halt
      repeat (MT) step(1, 0, 0, 0);
      repeat (4) step(0, 1, 1, 0);
      chk("halted_sticky", {31'b0, halted}, 32'd1);
      dmem_busy = 1'b1;
      do_reset();
      repeat (3) step(0, 0, 0, 0);

      // Randomized traffic with occasional long busy bursts and mid-run resets
      burst = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            logic b;
            if (burst == 0 && $urandom_range(0, 30) == 0) burst = $urandom_range(5, 10);
            b = (burst > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (burst > 0) burst--;
            step(b, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 40) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
